led_ws2812_serializer: RTL and testbench
========================================

// Module: led_ws2812_serializer
// PURPOSE
//  Downstream of the SPI pixel receiver: reads the 8x8 RGB pixel store one pixel at a time
//  over a read port and serializes it onto a single-wire WS2812 chain (64 LEDs).
//  A frame is a GRB bitstream followed by a reset/latch low gap. Frames are started by
//  `start` or by an update pulse from the receiver (`upd_valid`).
// PARAMETERS
//  NUM_PIX  64    pixels per frame; pix_addr is clog2(NUM_PIX) bits (6 at default)
//  BIT_CYC  63    clk cycles per WS2812 bit (1.26us @50MHz)
//  T0H_CYC  20    high cycles for a '0' bit (400ns); must satisfy 0 < T0H_CYC < T1H_CYC < BIT_CYC
//  T1H_CYC  40    high cycles for a '1' bit (800ns)
//  RST_CYC  2500  low cycles of latch gap after the last bit (50us)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  start      in   1   frame request pulse
//  upd_valid  in   1   pixel-store updated pulse (receiver data_valid)
//  pix_addr   out  6   pixel read address {row[2:0], col[2:0]}
//  pix_rgb    in   24  {R[23:16], G[15:8], B[7:0]}; valid the cycle after pix_addr changes
//  dout       out  1   WS2812 data line
//  busy       out  1   high from frame acceptance until frame_done
//  frame_done out  1   one-cycle pulse at end of latch gap
// BEHAVIOUR
//  Reset (async, rst_n low): dout=0, busy=0, frame_done=0, pix_addr=0, pending=0,
//   state=IDLE; all counters cleared. Asserted mid-frame: dout drops low immediately.
//  States: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
//  IDLE: start or upd_valid or pending -> LOAD, busy=1, pending cleared, pix_addr=index(0).
//  LOAD (2 cycles): cycle 1 addr settles, cycle 2 shift_reg <= {G,R,B} from pix_rgb,
//   pixel counter=0, bit counter=23 -> SHIFT. First dout rise is 3 cycles after the
//   accepting IDLE cycle.
//  SHIFT: per bit, cycle counter 0..BIT_CYC-1; dout=1 while cnt < (bit ? T1H_CYC:T0H_CYC),
//   else 0. Bits sent MSB first: G7..G0, R7..R0, B7..B0.
//  Prefetch: at cycle 0 of bit 23 of pixel p, pix_addr <= index(p+1) (held if p=NUM_PIX-1);
//   on last cycle of bit 0, shift_reg <= pix_rgb (next pixel) -> gapless, no idle between pixels.
//  After bit 0 of pixel NUM_PIX-1 completes -> LATCH: dout=0 for RST_CYC cycles, then
//   frame_done=1 for one cycle, busy=0, -> IDLE.
//  Frame length: 2 + NUM_PIX*24*BIT_CYC + RST_CYC cycles from acceptance to frame_done.
//  start while busy: ignored. upd_valid while busy: sets pending (one level, not counted);
//   IDLE re-launches a frame on the cycle after frame_done, so the latest store is always shown.
//  start and upd_valid same cycle in IDLE: one frame, pending stays 0.
//  Counters are sized to hold max(BIT_CYC, RST_CYC)-1; no wrap-around during a frame.
//  dout is a registered output (no combinational glitches).
// CONFIGURATION
//  SERPENTINE_EN defined: index(p) = odd row (p[5:3] odd) ? {p[5:3], ~p[2:0]} : p,
//   for zig-zag wired panels (pixel 8 reads addr 15, pixel 15 reads addr 8).
//  SERPENTINE_EN undefined: index(p) = p (row-major, pixel 8 reads addr 8).
// TESTING
//  1 Reset: rst_n low mid-SHIFT -> dout=0, busy=0 same cycle; after release stays IDLE, dout=0.
//  2 All pixels 24'hFF0000 (red), start -> per pixel 8 bits of 20-cycle highs, 8 of 40,
//    8 of 20; every bit period exactly 63 cycles; frame_done at 2+96768+2500 cycles.
//  3 Pixel 0 = 24'h123456 -> first 24 bits on dout decode as 0x341256 (G,R,B order).
//  4 upd_valid twice during a frame, start once -> exactly one extra frame, started the
//    cycle after frame_done; no third frame.
//  5 pix_addr sequence monitor: without SERPENTINE_EN reads 0..63 in order; with it, row 1
//    reads 15..8, row 2 reads 16..23; each addr held >= 24*63 cycles before sampling.
//  6 start asserted continuously -> back-to-back frames, dout low for exactly RST_CYC
//    cycles between last bit and next first rise (+3 cycle relaunch).

Source files
------------

// File: rtl/led_ws2812_serializer.sv
`timescale 1ns/1ps
// Pixel-store reader and single-wire WS2812 serializer (GRB, MSB first, then a latch gap).
// Optional build macro SERPENTINE_EN: odd rows are read right-to-left for zig-zag wired panels.
module led_ws2812_serializer #(
    parameter int unsigned NUM_PIX = 64,
    parameter int unsigned BIT_CYC = 63,
    parameter int unsigned T0H_CYC = 20,
    parameter int unsigned T1H_CYC = 40,
    parameter int unsigned RST_CYC = 2500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       upd_valid,
    output logic [$clog2(NUM_PIX)-1:0] pix_addr,
    input  logic [23:0]                pix_rgb,
    output logic                       dout,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned AW   = $clog2(NUM_PIX);
    localparam int unsigned MAXC = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] T0H      = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H      = CW'(T1H_CYC);
    localparam logic [AW-1:0] PIX_LAST = AW'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t        state_q, state_d;
    logic          load2_q, load2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [4:0]    bit_q,   bit_d;
    logic [AW-1:0] pix_q,   pix_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [23:0]   sh_q,    sh_d;
    logic          pend_q,  pend_d;
    logic          dout_q,  dout_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    function automatic logic [AW-1:0] pix_index(input logic [AW-1:0] p);
        logic [AW-1:0] r;
        r = p;
`ifdef SERPENTINE_EN
        if (p[3]) r[2:0] = ~p[2:0];
`endif
        return r;
    endfunction

    function automatic logic [23:0] to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        load2_d = load2_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        pend_d  = pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (start || upd_valid || pend_q) begin
                    state_d = S_LOAD;
                    load2_d = 1'b0;
                    pend_d  = 1'b0;
                    addr_d  = pix_index('0);
                    pix_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (!load2_q) begin
                    load2_d = 1'b1;
                end else begin
                    sh_d    = to_grb(pix_rgb);
                    pix_d   = '0;
                    bit_d   = 5'd23;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Next pixel's address goes out a full pixel early so pix_rgb is stable by bit 0.
                if (cnt_q == '0 && bit_q == 5'd23 && pix_q != PIX_LAST)
                    addr_d = pix_index(pix_q + 1'b1);
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q != '0) begin
                        bit_d = bit_q - 1'b1;
                    end else if (pix_q == PIX_LAST) begin
                        state_d = S_LATCH;
                    end else begin
                        pix_d = pix_q + 1'b1;
                        bit_d = 5'd23;
                        sh_d  = to_grb(pix_rgb);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && upd_valid) pend_d = 1'b1;

        // Outputs are decoded from next-state values so they appear registered, glitch-free.
        dout_d = (state_d == S_SHIFT) && (cnt_d < (sh_d[bit_d] ? T1H : T0H));
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_LATCH) && (cnt_d == RST_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            load2_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            sh_q    <= '0;
            pend_q  <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load2_q <= load2_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pix_addr   = addr_q;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_led_ws2812_serializer.sv
`timescale 1ns/1ps
// Randomized bench for led_ws2812_serializer against a cycle-offset behavioural model of a frame.
module tb_led_ws2812_serializer;

    localparam int NP   = 16;
    localparam int BC   = 10;
    localparam int T0   = 3;
    localparam int T1   = 6;
    localparam int RC   = 30;
    localparam int AW   = $clog2(NP);
    localparam int SB   = NP * 24 * BC;
    localparam int FLEN = 2 + SB + RC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          upd_valid = 1'b0;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_rgb;
    logic          dout;
    logic          busy;
    logic          frame_done;

    logic [23:0] mem [NP];
    int          total = 0;
    int          bad = 0;
    int          shown = 0;
    longint      cyc = 0;

    led_ws2812_serializer #(
        .NUM_PIX(NP),
        .BIT_CYC(BC),
        .T0H_CYC(T0),
        .T1H_CYC(T1),
        .RST_CYC(RC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .upd_valid (upd_valid),
        .pix_addr  (pix_addr),
        .pix_rgb   (pix_rgb),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) pix_rgb <= mem[pix_addr];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (shown < 30) begin
                shown++;
                $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
            end
        end
    endtask

    function automatic int idx(input int p);
`ifdef SERPENTINE_EN
        if ((p / 8) % 2 == 1) return (p / 8) * 8 + (7 - p % 8);
`endif
        return p;
    endfunction

    // Model: mk is the offset of the current cycle from the accepting idle cycle, -1 when idle.
    int mk = -1;
    bit mpend = 1'b0;
    int mhold = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mk = -1; mpend = 1'b0; mhold = 0;
        end else if (mk < 0) begin
            if (start || upd_valid || mpend) begin mk = 1; mpend = 1'b0; end
        end else begin
            if (upd_valid) mpend = 1'b1;
            if (mk == FLEN) begin mk = -1; mhold = idx(NP - 1); end
            else mk++;
        end
    end

    function automatic bit exp_dout(input int k);
        int j, p, b, c;
        logic [23:0] w, g;
        if (k < 3 || k > 2 + SB) return 1'b0;
        j = k - 3;
        p = j / (24 * BC);
        b = (j / BC) % 24;
        c = j % BC;
        w = mem[idx(p)];
        g = {w[15:8], w[23:16], w[7:0]};
        return c < (g[23 - b] ? T1 : T0);
    endfunction

    function automatic int exp_addr(input int k);
        int nxt;
        if (k < 0) return mhold;
        if (k <= 3) return idx(0);
        if (k - 4 >= SB) return idx(NP - 1);
        nxt = (k - 4) / (24 * BC) + 1;
        return idx(nxt < NP ? nxt : NP - 1);
    endfunction

    initial forever begin
        @(negedge clk);
        check("dout", dout, exp_dout(mk));
        check("busy", busy, mk >= 0);
        check("frame_done", frame_done, mk == FLEN);
        check("pix_addr", pix_addr, exp_addr(mk));
    end

    // Waveform decoder: pulse widths, bit periods, gaps, frame length.
    int hw = 0, since_rise = 0, low_run = 0, last_gap = -1, nb = 0;
    int n_short = 0, n_long = 0, frames = 0, flen_meas = 0, relaunch = -1;
    longint acc_cyc = 0, done_cyc = -1;
    bit in_frame = 1'b0, prev_d = 1'b0, prev_busy = 1'b0, got_first = 1'b0;
    logic [23:0] sh_mon = '0, first_word = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hw = 0; in_frame = 1'b0; prev_d = 1'b0; prev_busy = 1'b0;
            low_run = 0; since_rise = 0;
        end else begin
            if (busy && !prev_busy) begin
                acc_cyc = cyc - 1; in_frame = 1'b0; nb = 0; got_first = 1'b0;
                n_short = 0; n_long = 0;
                if (done_cyc >= 0) relaunch = int'(cyc - done_cyc);
            end
            if (frame_done) begin
                frames++; flen_meas = int'(cyc - acc_cyc); done_cyc = cyc; in_frame = 1'b0;
            end
            if (dout && !prev_d) begin
                if (in_frame) check("bit_period", since_rise, BC);
                else last_gap = low_run;
                in_frame = 1'b1; since_rise = 0; hw = 0;
            end
            if (!dout && prev_d) begin
                check("pulse_width_legal", (hw == T0 || hw == T1), 1);
                sh_mon = {sh_mon[22:0], hw == T1};
                nb++;
                if (hw == T1) n_long++; else n_short++;
                if (nb == 24 && !got_first) begin first_word = sh_mon; got_first = 1'b1; end
            end
            if (dout) begin hw++; low_run = 0; end else low_run++;
            since_rise++;
            prev_d = dout; prev_busy = busy;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic pulse_upd();
        @(posedge clk); #2 upd_valid = 1'b1;
        @(posedge clk); #2 upd_valid = 1'b0;
    endtask

    task automatic wait_k(input int t);
        int n;
        n = 0;
        while (mk != t && n < 4 * FLEN) begin @(negedge clk); n++; end
        check("wait_k_reached", mk == t, 1);
    endtask

    task automatic wait_frames(input int target, input int bound);
        int n;
        n = 0;
        while (frames < target && n < bound) begin @(negedge clk); n++; end
        check("frame_timeout", frames >= target, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(mk < 0 && !mpend && !busy) && n < bound) begin @(negedge clk); n++; end
        check("idle_timeout", (mk < 0 && !mpend && !busy), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NP; i++) mem[i] = 24'($urandom);
    endtask

    task automatic fill_red();
        for (int i = 0; i < NP; i++) mem[i] = 24'hFF0000;
    endtask

    initial begin
        int f0;
        fill_red();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_addr", pix_addr, 0);

        // All-red frame: pulse histogram and frame length.
        f0 = frames;
        pulse_start();
        wait_frames(f0 + 1, FLEN + 20);
        check("red_frame_len", flen_meas, 3872);
        check("red_short_pulses", n_short, 256);
        check("red_long_pulses", n_long, 128);
        wait_idle(100);

        // GRB ordering of pixel 0.
        fill_random();
        mem[0] = 24'h123456;
        pulse_start();
        wait_idle(FLEN + 100);
        check("first_word_grb", first_word, 24'h341256);

        // Two updates and a start during a frame: exactly one extra frame.
        fill_random();
        f0 = frames;
        pulse_start();
        wait_k(100);
        pulse_upd();
        wait_k(1000);
        pulse_upd();
        wait_k(2000);
        pulse_start();
        wait_frames(f0 + 2, 3 * FLEN);
        check("pending_relaunch", relaunch, 2);
        repeat (FLEN + 50) @(negedge clk);
        check("no_third_frame", frames, f0 + 2);
        check("idle_after_pending", busy, 0);

        // Address sequence literals for pixels 8 and 15.
        fill_random();
        pulse_start();
        wait_k(4 + 24 * BC * 7 + 5);
`ifdef SERPENTINE_EN
        check("addr_pixel8", pix_addr, 15);
`else
        check("addr_pixel8", pix_addr, 8);
`endif
        wait_k(4 + 24 * BC * 14 + 5);
`ifdef SERPENTINE_EN
        check("addr_pixel15", pix_addr, 8);
`else
        check("addr_pixel15", pix_addr, 15);
`endif
        wait_idle(FLEN + 100);

        // Start held high: back-to-back frames with a fixed low gap.
        fill_red();
        f0 = frames;
        @(posedge clk); #2 start = 1'b1;
        wait_frames(f0 + 1, FLEN + 20);
        repeat (10) @(negedge clk);
        check("latch_gap", last_gap, 40);
        check("cont_relaunch", relaunch, 2);
        @(posedge clk); #2 start = 1'b0;
        wait_idle(FLEN + 100);
        check("cont_frames", frames, f0 + 2);

        // Asynchronous reset in the middle of SHIFT.
        fill_random();
        pulse_start();
        wait_k(500);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", pix_addr, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_dout", dout, 0);

        // Randomized frames with random triggers and in-frame updates.
        for (int it = 0; it < 3; it++) begin
            fill_random();
            repeat ($urandom_range(0, 20)) @(posedge clk);
            if ($urandom_range(0, 1) == 1) pulse_start(); else pulse_upd();
            wait_k($urandom_range(10, FLEN / 2));
            if ($urandom_range(0, 1) == 1) pulse_upd();
            wait_idle(3 * FLEN + 100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        bad++;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
